// File: rtl/mac_feed_sequencer_pkg.sv
// Shared definitions for the MAC feed sequencer: fixed-point operand types,
// array geometry and the sequencer state encoding.
package mac_feed_sequencer_pkg;

  localparam int NU_COUNT = 4;
  localparam int Q_INT    = 8;
  localparam int Q_FRAC   = 8;
  localparam int Q_W      = Q_INT + Q_FRAC;
  localparam int ADDR_W   = 10;

  typedef logic [Q_INT-1:-Q_FRAC] fixed_t;
  typedef fixed_t [NU_COUNT-1:0]  fixed_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mac_feed_sequencer.sv
// Operand producer for the MAC array. It clears the accumulators, then streams
// in_len activations (broadcast) together with one weight row per element
// from two synchronous RAMs, using valid/ready flow control. The RAM output
// is presented directly on the cycle it arrives and captured into a hold
// register so the beat stays stable while the array stalls.
module mac_feed_sequencer
  import mac_feed_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       in_len,
  input  logic [ADDR_W-1:0]       x_base,
  input  logic [ADDR_W-1:0]       w_base,
  output logic                    x_rd_en,
  output logic [ADDR_W-1:0]       x_rd_addr,
  input  logic [Q_W-1:0]          x_rd_data,
  output logic                    w_rd_en,
  output logic [ADDR_W-1:0]       w_rd_addr,
  input  logic [NU_COUNT*Q_W-1:0] w_rd_data,
  output logic                    mac_clr,
  output logic                    mac_valid,
  input  logic                    mac_ready,
  output logic [Q_W-1:0]          mac_x,
  output logic [NU_COUNT*Q_W-1:0] mac_w,
  output logic                    mac_last,
  output logic                    busy,
  output logic                    done
);

  seq_state_t        state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] x_base_q;
  logic [ADDR_W-1:0] w_base_q;
  logic [ADDR_W-1:0] issue_cnt;
  logic [ADDR_W-1:0] accept_cnt;
  logic              fresh_q;
  fixed_t            x_hold;
  fixed_vec_t        w_hold;
  logic              rd_en;
  logic              accept;

  // Read issue only when the output stage frees up this cycle, plus operand muxing between fresh RAM data and the held beat
  always_comb begin
    rd_en     = (state == STREAM) && (issue_cnt < len_q) && (!mac_valid || mac_ready);
    accept    = mac_valid && mac_ready;
    mac_last  = mac_valid && (accept_cnt == len_q - ADDR_W'(1));
    x_rd_en   = rd_en;
    w_rd_en   = rd_en;
    x_rd_addr = '0;
    w_rd_addr = '0;
    if (rd_en) begin
      x_rd_addr = x_base_q + issue_cnt;
      w_rd_addr = w_base_q + issue_cnt;
    end
    mac_x = fresh_q ? x_rd_data : x_hold;
    mac_w = fresh_q ? w_rd_data : w_hold;
  end

  // Sequencer state, counters, valid flag and registered control pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      len_q      <= '0;
      x_base_q   <= '0;
      w_base_q   <= '0;
      issue_cnt  <= '0;
      accept_cnt <= '0;
      fresh_q    <= 1'b0;
      x_hold     <= '0;
      w_hold     <= '0;
      mac_valid  <= 1'b0;
      mac_clr    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      done    <= 1'b0;
      fresh_q <= rd_en;

      if (fresh_q) begin
        x_hold <= x_rd_data;
        w_hold <= w_rd_data;
      end

      if (rd_en) begin
        mac_valid <= 1'b1;
        issue_cnt <= issue_cnt + ADDR_W'(1);
      end else if (accept) begin
        mac_valid <= 1'b0;
      end

      if (accept) begin
        accept_cnt <= accept_cnt + ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (in_len != '0) begin
              state      <= CLEAR;
              len_q      <= in_len;
              x_base_q   <= x_base;
              w_base_q   <= w_base;
              issue_cnt  <= '0;
              accept_cnt <= '0;
              mac_clr    <= 1'b1;
              busy       <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state <= STREAM;
        end
        STREAM: begin
          if (accept && mac_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_feed_sequencer.sv
// Randomized self-checking bench for mac_feed_sequencer. Each dot-product run
// is predicted from memory contents: element i of a run is x[(xb+i) mod 2^ADDR_W]
// with weight row w[(wb+i) mod 2^ADDR_W], in order, exactly once each.
module tb_mac_feed_sequencer;
  import mac_feed_sequencer_pkg::*;

  localparam int MEM_N = 1 << ADDR_W;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    start = 1'b0;
  logic [ADDR_W-1:0]       in_len = '0;
  logic [ADDR_W-1:0]       x_base = '0;
  logic [ADDR_W-1:0]       w_base = '0;
  logic                    x_rd_en;
  logic [ADDR_W-1:0]       x_rd_addr;
  logic [Q_W-1:0]          x_rd_data;
  logic                    w_rd_en;
  logic [ADDR_W-1:0]       w_rd_addr;
  logic [NU_COUNT*Q_W-1:0] w_rd_data;
  logic                    mac_clr;
  logic                    mac_valid;
  logic                    mac_ready = 1'b1;
  logic [Q_W-1:0]          mac_x;
  logic [NU_COUNT*Q_W-1:0] mac_w;
  logic                    mac_last;
  logic                    busy;
  logic                    done;

  logic [Q_W-1:0]          xmem [MEM_N];
  logic [NU_COUNT*Q_W-1:0] wmem [MEM_N];

  int tests = 0;
  int fails = 0;

  mac_feed_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_len    (in_len),
    .x_base    (x_base),
    .w_base    (w_base),
    .x_rd_en   (x_rd_en),
    .x_rd_addr (x_rd_addr),
    .x_rd_data (x_rd_data),
    .w_rd_en   (w_rd_en),
    .w_rd_addr (w_rd_addr),
    .w_rd_data (w_rd_data),
    .mac_clr   (mac_clr),
    .mac_valid (mac_valid),
    .mac_ready (mac_ready),
    .mac_x     (mac_x),
    .mac_w     (mac_w),
    .mac_last  (mac_last),
    .busy      (busy),
    .done      (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Synchronous RAM models: data appears the cycle after the read strobe
  always @(posedge clk) begin
    if (x_rd_en) x_rd_data <= xmem[x_rd_addr];
    if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
  end

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({x_rd_en, x_rd_addr, w_rd_en, w_rd_addr, mac_clr, mac_valid,
                 mac_x, mac_w, mac_last, busy, done});
  endfunction

  // One dot-product run: start pulse, then per-cycle observation against the model
  task automatic apply_stimulus(input int len, input int xb, input int wb, input int ready_pct,
                                input int stall_beat, input int abort_beat, input bit noisy_start);
    int cyc = 0;
    int beats = 0;
    int xreads = 0;
    int wreads = 0;
    int clrs = 0;
    int dones = 0;
    int last_hs = 0;
    int stall_left = 2;
    bit stalled = 1'b0;
    bit finished = 1'b0;
    bit aborted = 1'b0;
    int idx;
    logic [Q_W-1:0]          held_x = '0;
    logic [NU_COUNT*Q_W-1:0] held_w = '0;

    @(negedge clk);
    start     = 1'b1;
    in_len    = ADDR_W'(len);
    x_base    = ADDR_W'(xb);
    w_base    = ADDR_W'(wb);
    mac_ready = 1'b1;

    while (!finished && cyc < 4 * len + 40) begin
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (stall_beat >= 0) begin
        if (stall_beat == beats && mac_valid && stall_left > 0) begin
          mac_ready = 1'b0;
          stall_left--;
        end else begin
          mac_ready = 1'b1;
        end
      end else begin
        mac_ready = ($urandom_range(99) < ready_pct);
      end
      #1;

      if (mac_clr) begin
        clrs++;
        check_output("clr_cycle", cyc, 1);
      end
      if (x_rd_en) begin
        check_output("x_addr", x_rd_addr, (xb + xreads) % MEM_N);
        xreads++;
      end
      if (w_rd_en) begin
        check_output("w_addr", w_rd_addr, (wb + wreads) % MEM_N);
        wreads++;
      end
      if (stalled) begin
        check_output("hold_valid", mac_valid, 1);
        check_output("hold_x", mac_x, held_x);
        check_output("hold_w", mac_w, held_w);
      end
      if (mac_valid && mac_ready) begin
        idx = (xb + beats) % MEM_N;
        check_output("beat_x", mac_x, xmem[idx]);
        idx = (wb + beats) % MEM_N;
        check_output("beat_w", mac_w, wmem[idx]);
        check_output("beat_last", mac_last, (beats == len - 1) ? 1 : 0);
        if (ready_pct == 100 && stall_beat < 0) check_output("beat_cycle", cyc, 3 + beats);
        beats++;
        last_hs = cyc;
      end
      stalled = mac_valid && !mac_ready;
      held_x  = mac_x;
      held_w  = mac_w;

      if (abort_beat >= 0 && beats == abort_beat) begin
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_output("abort_outputs_zero", all_outputs(), 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          #1;
          check_output("abort_no_done", {done, mac_valid, busy}, 0);
        end
        aborted  = 1'b1;
        finished = 1'b1;
      end else if (done) begin
        dones++;
        check_output("done_cycle", cyc, (len == 0) ? 1 : last_hs + 1);
        check_output("done_busy_low", busy, 0);
        check_output("done_valid_low", mac_valid, 0);
        finished = 1'b1;
      end else if (len != 0) begin
        check_output("busy_high", busy, 1);
      end

      if (!finished && noisy_start && busy && $urandom_range(1) == 1) begin
        start  = 1'b1;
        in_len = ADDR_W'($urandom_range(1, 20));
        x_base = ADDR_W'($urandom);
        w_base = ADDR_W'($urandom);
      end
    end

    if (!aborted) begin
      check_output("done_count", dones, 1);
      check_output("beat_count", beats, len);
      check_output("x_read_count", xreads, len);
      check_output("w_read_count", wreads, len);
      check_output("clr_count", clrs, (len != 0) ? 1 : 0);
      if (noisy_start && dones == 1) begin
        start  = 1'b1;
        in_len = ADDR_W'(5);
        @(negedge clk);
        start = 1'b0;
        #1;
        check_output("start_on_done_ignored", {mac_clr, busy, done}, 0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) begin
      xmem[i] = Q_W'($urandom);
      wmem[i] = {$urandom, $urandom};
    end

    repeat (3) @(negedge clk);
    #1;
    check_output("reset_outputs_zero", all_outputs(), 0);
    reset = 1'b1;

    // Known activations 1.0, 2.0, -0.5 at full rate
    xmem[100] = 16'h0100;
    xmem[101] = 16'h0200;
    xmem[102] = 16'hFF80;
    apply_stimulus(3, 100, 200, 100, -1, -1, 1'b0);

    // Two-cycle stall on the second beat
    apply_stimulus(4, 300, 301, 100, 1, -1, 1'b0);

    // Zero-length request
    apply_stimulus(0, 5, 6, 100, -1, -1, 1'b0);

    // Address wrap at the top of the RAM
    apply_stimulus(4, MEM_N - 2, MEM_N - 2, 100, -1, -1, 1'b0);

    // Reset mid-stream, then a fresh run
    apply_stimulus(8, 50, 60, 100, -1, 2, 1'b0);
    apply_stimulus(5, 70, 80, 100, -1, -1, 1'b0);

    // Weight slice order with spurious starts while busy
    wmem[400] = 64'h0004_0003_0002_0001;
    apply_stimulus(3, 400, 400, 70, -1, -1, 1'b1);

    // Random runs with random backpressure
    for (int t = 0; t < 10; t++) begin
      apply_stimulus(int'($urandom_range(1, 12)), int'($urandom_range(0, MEM_N - 1)),
                     int'($urandom_range(0, MEM_N - 1)), int'($urandom_range(40, 100)),
                     -1, -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
